// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch timekeeping core and the display
// driver: FSM state encoding, time field width and limits, and the helper
// that sizes the one-second prescaler.
package stopwatch_pkg;

    localparam int TIME_W = 7;

    localparam logic [TIME_W-1:0] MAX_SECONDS = 7'd59;
    localparam logic [TIME_W-1:0] MAX_MINUTES = 7'd59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_e;

    // Prescaler width for a given tick count; never narrower than one bit.
    function automatic int presc_width(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// rising_edge_detect
// Turns a debounced button level into a single-cycle event. The previous
// sample is registered; the event is high in the cycle where the level is 1
// and the previous sample is 0, so a held button produces exactly one event.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   synchronous, active-high; clears the previous sample
//   level_i in   debounced button level
//   rise_o  out  one-cycle event, valid for the next clock edge
module rising_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/stopwatch_timekeeper.sv
// stopwatch_timekeeper
// Timekeeping core of the stopwatch. Converts start/stop, clear and lap
// button levels into a running minutes:seconds count (binary, 0..59 each)
// that drives the seven-segment display driver directly.
//
// State | Meaning
// ------+-------------------------------------------
// IDLE  | stopped at 00:00
// RUNNING | prescaler and time counters advancing
// PAUSED  | counting frozen, prescaler fraction kept
//
// Parameters:
//   TICKS_PER_SECOND  clock cycles per counted second
//
// Ports:
//   clock      in   board clock, rising edge
//   reset      in   synchronous, active-high
//   start_stop in   button level; rising edge toggles run/pause
//   clear      in   button level; rising edge zeroes time and stops
//   lap        in   button level; rising edge toggles the lap hold
//   minutes    out  displayed minutes, 0..59
//   seconds    out  displayed seconds, 0..59
//   running    out  high in RUNNING
//   held       out  high while the lap hold is active
//   rollover   out  one-cycle pulse after the 59:59 -> 00:00 wrap
//
// Build option: define STOPWATCH_LAP_HOLD_EN to enable the lap hold. When
// undefined, lap is ignored, held stays 0 and the display always shows the
// live count; the port list does not change.
module stopwatch_timekeeper
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SECOND = 50_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_stop,
    input  logic              clear,
    input  logic              lap,
    output logic [TIME_W-1:0] minutes,
    output logic [TIME_W-1:0] seconds,
    output logic              running,
    output logic              held,
    output logic              rollover
);

    localparam int PRESC_W = presc_width(TICKS_PER_SECOND);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SECOND - 1);

    logic ss_ev;
    logic clr_ev;
    logic lap_ev;

    rising_edge_detect u_ss_edge (
        .clock   (clock),
        .reset   (reset),
        .level_i (start_stop),
        .rise_o  (ss_ev)
    );

    rising_edge_detect u_clr_edge (
        .clock   (clock),
        .reset   (reset),
        .level_i (clear),
        .rise_o  (clr_ev)
    );

    rising_edge_detect u_lap_edge (
        .clock   (clock),
        .reset   (reset),
        .level_i (lap),
        .rise_o  (lap_ev)
    );

    state_e              state_q,   state_d;
    logic [PRESC_W-1:0]  presc_q,   presc_d;
    logic [TIME_W-1:0]   sec_q,     sec_d;
    logic [TIME_W-1:0]   min_q,     min_d;
    logic [TIME_W-1:0]   sec_out_q, sec_out_d;
    logic [TIME_W-1:0]   min_out_q, min_out_d;
    logic                running_q, running_d;
    logic                held_q,    held_d;
    logic                roll_q,    roll_d;
    logic                tick;
    logic                freeze;

    // FSM, prescaler and time counters. Clear dominates everything in its
    // cycle, so a coincident start_stop event or tick is simply dropped.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        roll_d  = 1'b0;
        tick    = 1'b0;

        if (clr_ev) begin
            state_d = ST_IDLE;
            presc_d = '0;
            sec_d   = '0;
            min_d   = '0;
        end else begin
            if (ss_ev) begin
                case (state_q)
                    ST_IDLE:    state_d = ST_RUNNING;
                    ST_RUNNING: state_d = ST_PAUSED;
                    ST_PAUSED:  state_d = ST_RUNNING;
                    default:    state_d = ST_IDLE;
                endcase
            end

            // Counting follows the registered state, so the entry edge
            // itself does not count and PAUSED keeps the fraction.
            if (state_q == ST_RUNNING) begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick    = 1'b1;
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end

            if (tick) begin
                if (sec_q == MAX_SECONDS) begin
                    sec_d = '0;
                    if (min_q == MAX_MINUTES) begin
                        min_d  = '0;
                        roll_d = 1'b1;
                    end else begin
                        min_d = min_q + TIME_W'(1);
                    end
                end else begin
                    sec_d = sec_q + TIME_W'(1);
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    always_comb begin
        held_d = held_q;
        if (clr_ev) begin
            held_d = 1'b0;
        end else if (lap_ev && (state_q != ST_IDLE)) begin
            held_d = ~held_q;
        end
    end

    // The setting edge still loads the live count (that is the snapshot);
    // only edges where the hold was already active and stays active freeze.
    assign freeze = held_q & held_d;
`else
    logic unused_lap_ev;
    assign unused_lap_ev = lap_ev;
    assign held_d        = 1'b0;
    assign freeze        = 1'b0;
`endif

    always_comb begin
        sec_out_d = sec_d;
        min_out_d = min_d;
        if (freeze) begin
            sec_out_d = sec_out_q;
            min_out_d = min_out_q;
        end
    end

    assign running_d = (state_d == ST_RUNNING);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            sec_out_q <= '0;
            min_out_q <= '0;
            running_q <= 1'b0;
            held_q    <= 1'b0;
            roll_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            sec_out_q <= sec_out_d;
            min_out_q <= min_out_d;
            running_q <= running_d;
            held_q    <= held_d;
            roll_q    <= roll_d;
        end
    end

    assign minutes  = min_out_q;
    assign seconds  = sec_out_q;
    assign running  = running_q;
    assign held     = held_q;
    assign rollover = roll_q;

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
// tb_stopwatch_timekeeper
// Directed bench for stopwatch_timekeeper with TICKS_PER_SECOND = 4.
// Expected values are hand-computed; lap-hold expectations follow the
// STOPWATCH_LAP_HOLD_EN build option.
module tb_stopwatch_timekeeper;

    localparam int TPS = 4;

    logic       clock;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [6:0] minutes;
    logic [6:0] seconds;
    logic       running;
    logic       held;
    logic       rollover;

    int vectors;
    int miscompares;

    stopwatch_timekeeper #(.TICKS_PER_SECOND(TPS)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .minutes    (minutes),
        .seconds    (seconds),
        .running    (running),
        .held       (held),
        .rollover   (rollover)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int mm, input int ss);
        chk({tag, ".min"}, 32'(minutes), 32'(mm));
        chk({tag, ".sec"}, 32'(seconds), 32'(ss));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start_stop  = 1'b0;
        clear       = 1'b0;
        lap         = 1'b0;
        cycles(2);
        reset = 1'b0;

        // Reset state
        chk_time("rst", 0, 0);
        chk("rst.running",  32'(running),  0);
        chk("rst.held",     32'(held),     0);
        chk("rst.rollover", 32'(rollover), 0);

        // Basic count: button held 2 cycles, then released while running
        start_stop = 1'b1;
        cycles(1);
        chk("basic.enter_running", 32'(running), 1);
        chk_time("basic.enter", 0, 0);
        cycles(1);
        start_stop = 1'b0;
        cycles(38);
        chk_time("basic.39cyc", 0, 9);
        cycles(1);
        chk_time("basic.40cyc", 0, 10);
        chk("basic.running", 32'(running), 1);

        // Plain clear
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        chk_time("clear", 0, 0);
        chk("clear.running", 32'(running), 0);

        // Clear priority, coinciding with a tick edge, at 00:05
        start_stop = 1'b1;
        cycles(1);
        start_stop = 1'b0;
        cycles(23);
        chk_time("prio.before", 0, 5);
        clear      = 1'b1;
        start_stop = 1'b1;
        cycles(1);
        chk_time("prio.after", 0, 0);
        chk("prio.running", 32'(running), 0);
        cycles(8);
        chk_time("prio.held_btns", 0, 0);
        chk("prio.held_running", 32'(running), 0);
        clear      = 1'b0;
        start_stop = 1'b0;
        cycles(1);

        // Pause preserves the fractional second
        start_stop = 1'b1;
        cycles(1);
        start_stop = 1'b0;
        cycles(5);
        start_stop = 1'b1;
        cycles(1);
        start_stop = 1'b0;
        chk("pause.running", 32'(running), 0);
        chk_time("pause.enter", 0, 1);
        cycles(20);
        chk_time("pause.hold", 0, 1);
        start_stop = 1'b1;
        cycles(1);
        start_stop = 1'b0;
        chk("pause.resumed", 32'(running), 1);
        cycles(1);
        chk_time("pause.resume+1", 0, 1);
        cycles(1);
        chk_time("pause.resume+2", 0, 2);

        // Minute carry
        cycles(228);
        chk_time("carry.0059", 0, 59);
        cycles(4);
        chk_time("carry.0100", 1, 0);

        // Wrap 59:59 -> 00:00 with rollover pulse
        cycles(14156);
        chk_time("wrap.5959", 59, 59);
        chk("wrap.no_roll", 32'(rollover), 0);
        cycles(3);
        chk("wrap.pre_roll", 32'(rollover), 0);
        cycles(1);
        chk_time("wrap.0000", 0, 0);
        chk("wrap.roll", 32'(rollover), 1);
        cycles(1);
        chk("wrap.roll_off", 32'(rollover), 0);
        chk("wrap.running", 32'(running), 1);

        // Reset mid-run at 00:03
        clear = 1'b1;
        cycles(1);
        clear      = 1'b0;
        start_stop = 1'b1;
        cycles(1);
        start_stop = 1'b0;
        cycles(12);
        chk_time("rstrun.before", 0, 3);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        chk_time("rstrun.after", 0, 0);
        chk("rstrun.running",  32'(running),  0);
        chk("rstrun.rollover", 32'(rollover), 0);

        // Held button: one event only, until released and re-pressed
        start_stop = 1'b1;
        cycles(1);
        chk("hold_btn.start", 32'(running), 1);
        cycles(10);
        chk("hold_btn.still", 32'(running), 1);
        chk_time("hold_btn.time", 0, 2);
        start_stop = 1'b0;
        cycles(1);
        start_stop = 1'b1;
        cycles(1);
        start_stop = 1'b0;
        chk("hold_btn.repress", 32'(running), 0);

        // Lap in IDLE is ignored
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        lap   = 1'b1;
        cycles(1);
        lap   = 1'b0;
        chk("lap.idle_held", 32'(held), 0);

        // Lap hold at 00:03, 8 cycles, then release
        start_stop = 1'b1;
        cycles(1);
        start_stop = 1'b0;
        cycles(12);
        chk_time("lap.pre", 0, 3);
        lap = 1'b1;
        cycles(1);
        lap = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
        chk("lap.set_held", 32'(held), 1);
`else
        chk("lap.set_held", 32'(held), 0);
`endif
        chk_time("lap.set", 0, 3);
        cycles(7);
`ifdef STOPWATCH_LAP_HOLD_EN
        chk_time("lap.frozen", 0, 3);
        chk("lap.frozen_held", 32'(held), 1);
`else
        chk_time("lap.frozen", 0, 5);
        chk("lap.frozen_held", 32'(held), 0);
`endif
        lap = 1'b1;
        cycles(1);
        lap = 1'b0;
        chk_time("lap.release", 0, 5);
        chk("lap.release_held", 32'(held), 0);
        chk("lap.running", 32'(running), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
